// File: rtl/text_console_fetch.sv
// Text-mode fetch stage: raster tracking, character buffer and 8x16 font ROM addressing.
// Optional blinking underline cursor is built when TEXT_CURSOR_EN is defined.
module text_console_fetch #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_char,
`ifdef TEXT_CURSOR_EN
  input  logic [ADDR_W-1:0] cursor_addr,
`endif
  output logic [6:0]        ascii_code,
  output logic [3:0]        row,
  output logic [2:0]        col,
  input  logic              row_of_pixels,
  output logic              pixel_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int CELLS = COLS * ROWS;
  localparam int PX_W  = $clog2(COLS * 8 + 1);
  localparam int LN_W  = $clog2(ROWS * 16 + 1);

  localparam logic [PX_W-1:0]   PX_MAX   = PX_W'(COLS * 8);
  localparam logic [LN_W-1:0]   LN_MAX   = LN_W'(ROWS * 16);
  localparam logic [ADDR_W:0]   CELL_END = (ADDR_W + 1)'(CELLS);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [6:0]        SPACE    = 7'h20;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic blank;
    logic cur;
  } stage_t;

  logic [PX_W-1:0]   px_q, px_d;
  logic [LN_W-1:0]   ln_q, ln_d;
  logic [ADDR_W-1:0] cell_base_q, cell_base_d;
  logic              de_prev_q, de_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic              synced_q, synced_d;

  logic              vs_rise_s;
  logic              de_fall_s;
  logic              in_area_s;
  logic              pix_blank_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              cursor_hit_s;

  logic [6:0]        ascii_q, ascii_d;
  logic [3:0]        row_q, row_d;
  logic [2:0]        col_q, col_d;
  stage_t            s1_q, s1_d;
  stage_t            s2_q, s2_d;
  logic              pixel_q, pixel_d;
  logic              de_out_q, de_out_d;
  logic              hs_out_q, hs_out_d;
  logic              vs_out_q, vs_out_d;

  // Cells hold (char ^ space) so zero-initialised storage reads back as spaces.
  logic [6:0]        char_mem [CELLS];

  // Edge detection and text-area classification of the current sample.
  always_comb begin
    vs_rise_s   = vsync_in & ~vs_prev_q;
    de_fall_s   = ~de_in & de_prev_q;
    in_area_s   = (px_q < PX_MAX) && (ln_q < LN_MAX);
    pix_blank_s = ~in_area_s | ~synced_q;
    rd_en_s     = in_area_s & de_in;
    rd_addr_s   = cell_base_q + ADDR_W'(px_q[PX_W-1:3]);
  end

  // Raster counters, per-line cell base and sync tracking.
  always_comb begin
    px_d        = px_q;
    ln_d        = ln_q;
    cell_base_d = cell_base_q;
    synced_d    = synced_q;
    de_prev_d   = de_in;
    vs_prev_d   = vsync_in;
    if (vs_rise_s) begin
      px_d        = '0;
      ln_d        = '0;
      cell_base_d = '0;
      synced_d    = 1'b1;
    end else if (de_fall_s) begin
      px_d = '0;
      if (ln_q < LN_MAX) begin
        ln_d = ln_q + LN_W'(1);
        if (ln_q[3:0] == 4'hF) begin
          cell_base_d = cell_base_q + COLS_A;
        end else begin
          cell_base_d = cell_base_q;
        end
      end else begin
        ln_d = ln_q;
      end
    end else if (de_in) begin
      if (px_q < PX_MAX) begin
        px_d = px_q + PX_W'(1);
      end else begin
        px_d = px_q;
      end
    end else begin
      px_d = px_q;
    end
  end

  // Raster state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q        <= '0;
      ln_q        <= '0;
      cell_base_q <= '0;
      synced_q    <= 1'b0;
      de_prev_q   <= 1'b0;
      vs_prev_q   <= 1'b0;
    end else begin
      px_q        <= px_d;
      ln_q        <= ln_d;
      cell_base_q <= cell_base_d;
      synced_q    <= synced_d;
      de_prev_q   <= de_prev_d;
      vs_prev_q   <= vs_prev_d;
    end
  end

  // Character buffer write port; out-of-range cells are ignored.
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < CELL_END)) begin
      char_mem[wr_addr] <= wr_char ^ SPACE;
    end
  end

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_q, frame_d;

  // Frame counter whose MSB is the cursor blink phase.
  always_comb begin
    frame_d = frame_q;
    if (vs_rise_s) begin
      frame_d = frame_q + 5'd1;
    end else begin
      frame_d = frame_q;
    end
    cursor_hit_s = frame_q[4] & in_area_s & (rd_addr_s == cursor_addr) & (ln_q[3:1] == 3'b111);
  end

  // Frame counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= 5'd0;
    end else begin
      frame_q <= frame_d;
    end
  end
`else
  assign cursor_hit_s = 1'b0;
`endif

  // Fetch pipeline: ROM address stage, ROM wait stage, pixel stage.
  always_comb begin
    ascii_d  = ascii_q;
    row_d    = ln_q[3:0];
    col_d    = px_q[2:0];
    s1_d     = '{de: de_in, hs: hsync_in, vs: vsync_in, blank: pix_blank_s, cur: cursor_hit_s};
    s2_d     = s1_q;
    de_out_d = s2_q.de;
    hs_out_d = s2_q.hs;
    vs_out_d = s2_q.vs;
    pixel_d  = (row_of_pixels ^ s2_q.cur) & s2_q.de & ~s2_q.blank;
    if (rd_en_s) begin
      ascii_d = char_mem[rd_addr_s] ^ SPACE;
    end else begin
      ascii_d = ascii_q;
    end
  end

  // Pipeline and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ascii_q  <= 7'h00;
      row_q    <= 4'h0;
      col_q    <= 3'h0;
      s1_q     <= '0;
      s2_q     <= '0;
      pixel_q  <= 1'b0;
      de_out_q <= 1'b0;
      hs_out_q <= 1'b0;
      vs_out_q <= 1'b0;
    end else begin
      ascii_q  <= ascii_d;
      row_q    <= row_d;
      col_q    <= col_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pixel_q  <= pixel_d;
      de_out_q <= de_out_d;
      hs_out_q <= hs_out_d;
      vs_out_q <= vs_out_d;
    end
  end

  assign ascii_code = ascii_q;
  assign row        = row_q;
  assign col        = col_q;
  assign pixel_out  = pixel_q;
  assign de_out     = de_out_q;
  assign hsync_out  = hs_out_q;
  assign vsync_out  = vs_out_q;

endmodule

// File: tb/tb_text_console_fetch.sv
// Self-checking bench for text_console_fetch on a reduced 10x4 character screen,
// with a hashed font ROM stub and a position/character-array reference model.
module tb_text_console_fetch;

  localparam int COLS   = 10;
  localparam int ROWS   = 4;
  localparam int ADDR_W = 8;
  localparam int CELLS  = COLS * ROWS;
  localparam int TW     = COLS * 8;
  localparam int TH     = ROWS * 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              de_in, hsync_in, vsync_in;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_char;
`ifdef TEXT_CURSOR_EN
  logic [ADDR_W-1:0] cursor_addr;
`endif
  logic [6:0]        ascii_code;
  logic [3:0]        row;
  logic [2:0]        col;
  logic              row_of_pixels;
  logic              pixel_out, de_out, hsync_out, vsync_out;

  int errors = 0;
  int checks = 0;

  logic [6:0] mem [CELLS];
  bit         synced_m;
  bit         prev_vs;
  logic [3:0] expq [$];

  text_console_fetch #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
`ifdef TEXT_CURSOR_EN
    .cursor_addr(cursor_addr),
`endif
    .ascii_code(ascii_code), .row(row), .col(col),
    .row_of_pixels(row_of_pixels),
    .pixel_out(pixel_out), .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Hashed glyph: spaces are empty, other codes give a scrambled pattern.
  function automatic logic font(input logic [6:0] c, input logic [3:0] r, input logic [2:0] k);
    logic [15:0] h;
    h = {2'b00, c, r, k} * 16'd40503;
    return (c != 7'h20) & h[9];
  endfunction

  always @(posedge clk) row_of_pixels <= font(ascii_code, row, col);

  task automatic step(input logic de, input logic hs, input logic vs, input int x, input int y);
    logic       pix;
    logic [6:0] ch;
    bit         in_area;
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    pix      = 1'b0;
    ch       = 7'h00;
    in_area  = de && (x < TW) && (y < TH);
    if (in_area) ch = mem[(y / 16) * COLS + (x / 8)];
    if (in_area && synced_m) pix = font(ch, 4'(y % 16), 3'(x % 8));
    expq.push_back({de, hs, vs, pix});
    if (vs && !prev_vs) synced_m = 1'b1;
    prev_vs = vs;
    if (wr_en && (int'(wr_addr) < CELLS)) mem[wr_addr] = wr_char;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    checks++;
    if ({de_out, hsync_out, vsync_out, pixel_out} !== expq[0]) begin
      errors++;
      $display("FAIL timing_pixel t=%0t got de/hs/vs/pix=%b expected=%b", $time,
               {de_out, hsync_out, vsync_out, pixel_out}, expq[0]);
    end
    void'(expq.pop_front());
    if (in_area && synced_m) begin
      checks++;
      if ({ascii_code, row, col} !== {ch, 4'(y % 16), 3'(x % 8)}) begin
        errors++;
        $display("FAIL rom_addr x=%0d y=%0d got ascii=%h row=%0d col=%0d expected ascii=%h row=%0d col=%0d",
                 x, y, ascii_code, row, col, ch, y % 16, x % 8);
      end
    end
  endtask

  task automatic write_cell(input int a, input logic [6:0] c);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_char = c;
    step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic run_frame(input int w, input int h, input bit rnd_wr);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int y = 0; y < h; y++) begin
      int hb;
      hb = int'($urandom_range(3, 9));
      for (int i = 0; i < hb; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
      for (int x = 0; x < w; x++) begin
        if (rnd_wr && ($urandom_range(0, 15) == 0)) begin
          wr_en   = 1'b1;
          wr_addr = ADDR_W'($urandom_range(0, CELLS + 3));
          wr_char = 7'($urandom);
        end
        step(1'b1, 1'b0, 1'b0, x, y);
      end
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({ascii_code, row, col, pixel_out, de_out, hsync_out, vsync_out} !== 18'd0) begin
      errors++;
      $display("FAIL %s got ascii=%h row=%0d col=%0d pix=%b de=%b hs=%b vs=%b expected all 0",
               tag, ascii_code, row, col, pixel_out, de_out, hsync_out, vsync_out);
    end
  endtask

  task automatic restart_model();
    expq.delete();
    expq.push_back(4'b0000);
    expq.push_back(4'b0000);
    synced_m = 1'b0;
    prev_vs  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_char = 7'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    restart_model();
  endtask

  task automatic test_spaces_frame();
    run_frame(TW, TH, 1'b0);
  endtask

  task automatic test_char_a();
    write_cell(0, 7'h41);
    run_frame(TW, TH, 1'b0);
  endtask

  task automatic test_last_cell();
    write_cell(CELLS - 1, 7'h58);
    write_cell(CELLS, 7'h33);
    write_cell(CELLS + 2, 7'h34);
    run_frame(TW, TH, 1'b0);
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 12; i++) write_cell(int'($urandom_range(0, CELLS - 1)), 7'($urandom));
      run_frame(TW, TH, 1'b1);
    end
  endtask

  task automatic test_oversize();
    run_frame(TW + 20, TH + 6, 1'b1);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int y = 0; y < 3; y++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
      for (int x = 0; x < TW; x++) step(1'b1, 1'b0, 1'b0, x, y);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 0, 0);
    for (int x = 0; x < 21; x++) step(1'b1, 1'b0, 1'b0, x, 3);
    rst = 1'b1;
    de_in = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    rst = 1'b0;
    restart_model();
    for (int x = 22; x < TW; x++) step(1'b1, 1'b0, 1'b0, x, 3);
    for (int y = 4; y < 8; y++) begin
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
      for (int x = 0; x < TW; x++) step(1'b1, 1'b0, 1'b0, x, y);
    end
    run_frame(TW, TH, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < CELLS; i++) mem[i] = 7'h20;
`ifdef TEXT_CURSOR_EN
    cursor_addr = '0;
`endif
    test_reset();
    test_spaces_frame();
    test_char_a();
    test_last_cell();
    test_random_frames();
    test_oversize();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/text_console_fetch.md
# text_console_fetch

Text-mode fetch stage that drives the 8x16 font ROM (`ascii_code`/`row`/`col` → one-cycle `row_of_pixels`). It sits between the display timing generator and the LVDS serializer input. It tracks the raster position from incoming sync/DE, reads the character code from an internal dual-port character buffer, and addresses the font ROM. It then returns the ROM pixel together with sync/DE delayed to match.

## Interface
Parameters:
- `COLS`, 80, character columns per line (text width = COLS*8 px)
- `ROWS`, 30, character rows per frame (text height = ROWS*16 lines)
- `ADDR_W`, 12, character buffer address width; must satisfy 2^ADDR_W ≥ COLS*ROWS

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous active-high reset
- `de_in`  in  1  active video from timing generator
- `hsync_in`  in  1  horizontal sync, active-high
- `vsync_in`  in  1  vertical sync, active-high; rising edge = frame start
- `wr_en`  in  1  character buffer write strobe
- `wr_addr`  in  ADDR_W  write cell index, row-major (row*COLS + col)
- `wr_char`  in  7  ASCII code to store
- `ascii_code`  out  7  to font ROM
- `row`  out  4  glyph scanline to font ROM
- `col`  out  3  glyph pixel column to font ROM (0 = leftmost pixel)
- `row_of_pixels`  in  1  font ROM pixel, valid one cycle after `ascii_code`/`row`/`col`
- `pixel_out`  out  1  1 = foreground
- `de_out`, `hsync_out`, `vsync_out`  out  1 each  timing delayed to match `pixel_out`

## Operation
- Character buffer: COLS*ROWS x 7 bit, one write port and one synchronous read port. Initialised to 7'h20 (space).
  - Writes with `wr_addr` ≥ COLS*ROWS are dropped.
  - A read and a write to the same cell in the same cycle returns the old data.
- Raster counters:
  - `px` (pixel in line) increments on each `de_in`=1 cycle.
  - `ln` (line) increments on each falling edge of `de_in`; `px` clears at the same edge.
  - A rising edge of `vsync_in` clears `px`, `ln` and `cell_base`.
- Cell index is computed without a multiplier:
  - `cell = cell_base + px[..3]`.
  - `cell_base` += COLS when a line with `ln[3:0]`=15 ends.
- `px` saturates at COLS*8 and `ln` saturates at ROWS*16. Positions outside the text area are "blank": no RAM read is required and the pixel is forced to 0.
- Sync state:
  - `synced` clears on reset and sets on the first `vsync_in` rising edge.
  - While `synced`=0, `pixel_out` = 0; timing still passes through.
- Pipeline (cycle T = `de_in` sample for pixel (px,ln)):
  - T: read address = `cell`.
  - T+1: `ascii_code` = RAM data, `row` = ln[3:0], `col` = px[2:0] (all registered).
  - T+2: `row_of_pixels` valid.
  - T+3: `pixel_out` = `row_of_pixels` & de & ~blank & `synced` (registered).
- The delay lines for de/hsync/vsync/blank are 3 registers deep.
- Reset values: `ascii_code`=0, `row`=0, `col`=0, `pixel_out`=0, `de_out`=0, `hsync_out`=0, `vsync_out`=0; counters 0. Buffer contents are not cleared by reset.
- Reset mid-frame: outputs go to 0 next cycle. Pixels stay blank until the next `vsync_in` rising edge.

## Timing
- Latency is exactly 3 `clk` from `de_in`/`hsync_in`/`vsync_in` to `de_out`/`hsync_out`/`vsync_out`/`pixel_out`.
- ROM address outputs lead `pixel_out` by 2 cycles.
- A write is visible to the read port from the cycle after `wr_en`.
- Throughput is 1 pixel/clk, with no stalls.
- Simultaneous falling `de_in` and rising `vsync_in`: the vsync clear wins.

## Configuration
- `TEXT_CURSOR_EN` defined:
  - Adds input `cursor_addr` (ADDR_W) and a 5-bit frame counter that increments on each `vsync_in` rising edge.
  - While counter[4]=1, pixels of the cell equal to `cursor_addr` on glyph rows 14–15 are inverted, inside the text area only.
  - Cursor timing is aligned through the same 3-stage delay.
- `TEXT_CURSOR_EN` undefined: there is no cursor port and no counter. `pixel_out` follows the base equation.

## Test plan
- Reset, then vsync pulse, then 640x480 DE frame with buffer holding spaces → `pixel_out`=0 all frame; `de_out` equals `de_in` delayed 3 cycles.
- Write 7'h41 at addr 0 → first line pixels 0–7 give `ascii_code`=7'h41, `row`=0, `col`=0..7 on consecutive cycles; `pixel_out` mirrors the ROM stub 3 cycles after `de_in`.
- Write 7'h58 at addr COLS*ROWS-1 → it appears at px 632–639, ln 464–479. Write at addr 2400 → no change anywhere.
- DE 800 px wide, 500 lines → `pixel_out`=0 for px ≥ 640 and ln ≥ 480; counters do not wrap.
- Assert `rst` mid-line → all outputs 0 next cycle; `pixel_out` stays 0 until the next vsync rising edge, then the frame renders correctly.
- `TEXT_CURSOR_EN` with `cursor_addr`=81 → cell (1,1) rows 14–15 inverted in frames 16–31 and not inverted in frames 0–15.
